// File: rtl/qed_pkg.sv
// Shared types and constants for the QED instruction-memory loader.
package qed_pkg;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_FULL  = 2'd2
  } qed_state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/qed_sat_cnt.sv
// Saturating up-counter with synchronous active-high reset.
module qed_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/qed_imem_loader.sv
// Writes the QED instruction stream into the instruction RAM, with optional NOP
// pre-clear, held core reset until PREFILL words land, and wrap or stop-and-drop on full.
module qed_imem_loader
  import qed_pkg::*;
#(
  parameter int                DEPTH     = 32,
  parameter int                DATA_W    = 32,
  parameter int                PREFILL   = 8,
  parameter int                WRAP      = 0,
  parameter int                CLEAR_EN  = 1,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEFAULT),
  parameter int                CNT_W     = 16,
  localparam int               ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              qed_vld_i,
  input  logic [DATA_W-1:0] qed_instr_i,
  output logic              qed_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_w_en_o,
  output logic              core_rst_o,
  output logic              full_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  localparam int                LCNT_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [LCNT_W-1:0] PREFILL_C = LCNT_W'(PREFILL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("qed_imem_loader: DEPTH must be a power of 2 and >= 2");
  end
  if ((PREFILL < 0) || (PREFILL > DEPTH)) begin : g_bad_prefill
    $error("qed_imem_loader: PREFILL must be within 0..DEPTH");
  end

  qed_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LCNT_W-1:0] loaded_q, loaded_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              w_en_d, full_d, stall_d, core_rst_d;
  logic              accept, drop;

  // Handshake: a word is taken when qed_vld_i is high while qed_stall_o is low;
  // a valid word seen while qed_stall_o is high is discarded and counted, never retried.
  assign accept = qed_vld_i && !qed_stall_o && (state_q == S_LOAD);
  assign drop   = qed_vld_i && qed_stall_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= (CLEAR_EN != 0) ? S_CLEAR : S_LOAD;
      clr_ptr_q   <= '0;
      wr_ptr_q    <= '0;
      loaded_q    <= '0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_w_en_o  <= 1'b0;
      full_o      <= 1'b0;
      qed_stall_o <= (CLEAR_EN != 0);
      core_rst_o  <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      loaded_q    <= loaded_d;
      mem_addr_o  <= addr_d;
      mem_data_o  <= data_d;
      mem_w_en_o  <= w_en_d;
      full_o      <= full_d;
      qed_stall_o <= stall_d;
      core_rst_o  <= core_rst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    loaded_d   = loaded_q;
    addr_d     = mem_addr_o;
    data_d     = mem_data_o;
    w_en_d     = 1'b0;
    full_d     = full_o;
    stall_d    = qed_stall_o;
    core_rst_d = core_rst_o;

    case (state_q)
      S_CLEAR: begin
        w_en_d    = 1'b1;
        addr_d    = clr_ptr_q;
        data_d    = NOP_INSTR;
        stall_d   = 1'b1;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST_ADDR) state_d = S_LOAD;
      end
      S_LOAD: begin
        stall_d = 1'b0;
        if (accept) begin
          w_en_d   = 1'b1;
          addr_d   = wr_ptr_q;
          data_d   = qed_instr_i;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (loaded_q != PREFILL_C) loaded_d = loaded_q + LCNT_W'(1);
          if (wr_ptr_q == LAST_ADDR) begin
            full_d = 1'b1;
            if (WRAP == 0) begin
              state_d = S_FULL;
              stall_d = 1'b1;
            end
          end
        end
      end
      S_FULL: begin
        stall_d = 1'b1;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase

    // Release one cycle after the PREFILL-th write is on the RAM port; sticky until reset.
    if ((state_q != S_CLEAR) && (loaded_q == PREFILL_C)) core_rst_d = 1'b0;
  end

  qed_sat_cnt #(.W(CNT_W)) u_drop_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (drop),
    .cnt_o (drop_cnt_o)
  );

endmodule

// File: tb/tb_qed_imem_loader.sv
// Directed bench for qed_imem_loader: three DEPTH=8 instances (stop/PREFILL=3, wrap/PREFILL=0,
// stop/PREFILL=8 with a 2-bit drop counter) share one stimulus stream.
module tb_qed_imem_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst, vld;
  logic [31:0] instr;

  logic        a_stall, a_wen, a_crst, a_full;
  logic [2:0]  a_addr;
  logic [31:0] a_data;
  logic [15:0] a_drop;

  logic        b_stall, b_wen, b_crst, b_full;
  logic [2:0]  b_addr;
  logic [31:0] b_data;
  logic [15:0] b_drop;

  logic        c_stall, c_wen, c_crst, c_full;
  logic [2:0]  c_addr;
  logic [31:0] c_data;
  logic [1:0]  c_drop;

  int n_tests = 0;
  int n_fail  = 0;

  logic [34:0] exp_q[$];
  logic [31:0] abc[3];

  qed_imem_loader #(.DEPTH(8), .DATA_W(32), .PREFILL(3), .WRAP(0), .CLEAR_EN(1), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_i(rst), .qed_vld_i(vld), .qed_instr_i(instr), .qed_stall_o(a_stall),
    .mem_addr_o(a_addr), .mem_data_o(a_data), .mem_w_en_o(a_wen), .core_rst_o(a_crst),
    .full_o(a_full), .drop_cnt_o(a_drop)
  );

  qed_imem_loader #(.DEPTH(8), .DATA_W(32), .PREFILL(0), .WRAP(1), .CLEAR_EN(1), .CNT_W(16)) u_b (
    .clk_i(clk), .rst_i(rst), .qed_vld_i(vld), .qed_instr_i(instr), .qed_stall_o(b_stall),
    .mem_addr_o(b_addr), .mem_data_o(b_data), .mem_w_en_o(b_wen), .core_rst_o(b_crst),
    .full_o(b_full), .drop_cnt_o(b_drop)
  );

  qed_imem_loader #(.DEPTH(8), .DATA_W(32), .PREFILL(8), .WRAP(0), .CLEAR_EN(1), .CNT_W(2)) u_c (
    .clk_i(clk), .rst_i(rst), .qed_vld_i(vld), .qed_instr_i(instr), .qed_stall_o(c_stall),
    .mem_addr_o(c_addr), .mem_data_o(c_data), .mem_w_en_o(c_wen), .core_rst_o(c_crst),
    .full_o(c_full), .drop_cnt_o(c_drop)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear();
    for (int k = 0; k < 8; k++) exp_q.push_back({3'(k), NOP});
  endtask

  task automatic run_clear(input string tag);
    for (int k = 0; k < 8; k++) begin
      tick();
      check({tag, "_addr"}, 64'(a_addr), 64'(k));
      check({tag, "_stall"}, 64'(a_stall), 64'd1);
      if (k == 7) check({tag, "_b_crst_held"}, 64'(b_crst), 64'd1);
    end
  endtask

  // scoreboard on instance a's RAM write port
  always @(negedge clk) begin
    logic [34:0] e;
    if (a_wen) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 64'({a_addr, a_data}), 64'h7_ffff_ffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("wr_a", 64'({a_addr, a_data}), 64'(e));
      end
    end
  end

  initial begin
    rst   = 1'b1;
    vld   = 1'b0;
    instr = '0;
    abc[0] = 32'hAAAA_0001;
    abc[1] = 32'hBBBB_0002;
    abc[2] = 32'hCCCC_0003;
    repeat (2) tick();

    check("rst_wen",   64'(a_wen),   64'd0);
    check("rst_addr",  64'(a_addr),  64'd0);
    check("rst_data",  64'(a_data),  64'd0);
    check("rst_crst",  64'(a_crst),  64'd1);
    check("rst_full",  64'(a_full),  64'd0);
    check("rst_drop",  64'(a_drop),  64'd0);
    check("rst_stall", 64'(a_stall), 64'd1);

    // clear with vld held for the 8 clear cycles: all dropped, none written
    push_clear();
    rst   = 1'b0;
    vld   = 1'b1;
    instr = 32'hDEAD_BEEF;
    run_clear("clr1");
    vld = 1'b0;
    tick();
    check("clr1_stall_low", 64'(a_stall), 64'd0);
    check("clr1_wen_idle",  64'(a_wen),   64'd0);
    check("a_crst_wait",    64'(a_crst),  64'd1);
    check("b_crst_pf0",     64'(b_crst),  64'd0);
    check("c_crst_wait",    64'(c_crst),  64'd1);
    check("a_drop_clear",   64'(a_drop),  64'd8);
    check("b_drop_clear",   64'(b_drop),  64'd8);
    check("c_drop_sat",     64'(c_drop),  64'd3);

    // PREFILL=3: A, B, C back-to-back
    for (int i = 0; i < 3; i++) exp_q.push_back({3'(i), abc[i]});
    vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr = abc[i];
      tick();
    end
    vld = 1'b0;
    check("a_crst_at_c_write", 64'(a_crst), 64'd1);
    tick();
    check("a_crst_released", 64'(a_crst), 64'd0);

    // two more words, then reset mid-load
    exp_q.push_back({3'd3, 32'hDDDD_0004});
    exp_q.push_back({3'd4, 32'hEEEE_0005});
    vld   = 1'b1;
    instr = 32'hDDDD_0004;
    tick();
    instr = 32'hEEEE_0005;
    tick();
    vld = 1'b0;
    tick();
    check("a_crst_sticky", 64'(a_crst), 64'd0);

    rst = 1'b1;
    tick();
    check("rst2_crst",  64'(a_crst),  64'd1);
    check("rst2_addr",  64'(a_addr),  64'd0);
    check("rst2_wen",   64'(a_wen),   64'd0);
    check("rst2_stall", 64'(a_stall), 64'd1);
    check("rst2_drop",  64'(a_drop),  64'd0);
    check("rst2_full",  64'(a_full),  64'd0);
    push_clear();
    rst = 1'b0;
    run_clear("clr2");
    tick();
    check("clr2_stall_low", 64'(a_stall), 64'd0);
    check("clr2_b_crst",    64'(b_crst),  64'd0);
    check("clr2_a_crst",    64'(a_crst),  64'd1);

    // ten back-to-back words: a stops after 8, b wraps, c releases core at 8
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 32'hC0DE_0000 + 32'(i)});
    vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr = 32'hC0DE_0000 + 32'(i);
      tick();
      check("b_wen",  64'(b_wen),  64'd1);
      check("b_addr", 64'(b_addr), 64'(i % 8));
      check("b_data", 64'(b_data), 64'(32'hC0DE_0000 + 32'(i)));
      if (i >= 8) check("a_no_write_full", 64'(a_wen), 64'd0);
      if (i == 6) begin
        check("a_full_pre",  64'(a_full),  64'd0);
        check("a_stall_pre", 64'(a_stall), 64'd0);
        check("b_full_pre",  64'(b_full),  64'd0);
      end
      if (i == 7) begin
        check("a_full_at_last",  64'(a_full),  64'd1);
        check("a_stall_at_last", 64'(a_stall), 64'd1);
        check("b_full_at_last",  64'(b_full),  64'd1);
        check("c_addr_last",     64'(c_addr),  64'd7);
        check("c_data_last",     64'(c_data),  64'hC0DE_0007);
        check("c_crst_at_8th",   64'(c_crst),  64'd1);
        check("c_full_at_last",  64'(c_full),  64'd1);
      end
      if (i == 8) begin
        check("c_crst_after_8th", 64'(c_crst),  64'd0);
        check("c_stall_full",     64'(c_stall), 64'd1);
      end
    end
    vld = 1'b0;
    repeat (2) tick();
    check("a_drop_full",  64'(a_drop),  64'd2);
    check("b_drop_wrap",  64'(b_drop),  64'd0);
    check("c_drop_full",  64'(c_drop),  64'd2);
    check("a_full_stick", 64'(a_full),  64'd1);
    check("a_stall_stick",64'(a_stall), 64'd1);
    check("b_full_stick", 64'(b_full),  64'd1);
    check("b_stall_wrap", 64'(b_stall), 64'd0);
    check("c_wen_idle",   64'(c_wen),   64'd0);
    check("a_crst_final", 64'(a_crst),  64'd0);
    check("sb_empty",     64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
